// File: rtl/usb_rx_unstuff_ctrl_if.sv
// Handshake bundle between the USB receive front end and the bit-unstuffing controller.
// The master side drives line events; the slave side (the controller) returns bytes and status.
interface usb_rx_unstuff_ctrl_if;
  logic       start_rx;
  logic       shift_enable;
  logic       d_orig;
  logic       eop;
  logic [7:0] rx_data;
  logic       byte_valid;
  logic       bit_discard;
  logic       stuff_err;
  logic       byte_err;
  logic       pkt_done;
  logic       busy;

  modport master (
    output start_rx, shift_enable, d_orig, eop,
    input  rx_data, byte_valid, bit_discard, stuff_err, byte_err, pkt_done, busy
  );

  modport slave (
    input  start_rx, shift_enable, d_orig, eop,
    output rx_data, byte_valid, bit_discard, stuff_err, byte_err, pkt_done, busy
  );
endinterface

// File: rtl/usb_rx_unstuff_ctrl.sv
// USB receive bit-unstuffing controller: assembles LSB-first bytes from NRZI-decoded bits,
// drops the stuffed zero after six ones, and flags stuffing and partial-byte errors.
module usb_rx_unstuff_ctrl (
  input logic                   clk,
  input logic                   n_rst,
  usb_rx_unstuff_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RECV, STUFF, ERROR} state_t;

  state_t     state, state_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [2:0] ones_cnt, ones_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [7:0] rx_data_q, rx_data_nxt;
  logic       byte_valid_q, byte_valid_nxt;
  logic       bit_discard_q, bit_discard_nxt;
  logic       stuff_err_q, stuff_err_nxt;
  logic       byte_err_q, byte_err_nxt;
  logic       pkt_done_q, pkt_done_nxt;
  logic       busy_q, busy_nxt;

  always_ff @(posedge clk) begin
    if (n_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bit_cnt_nxt     = bit_cnt;
    ones_cnt_nxt    = ones_cnt;
    shreg_nxt       = shreg;
    rx_data_nxt     = rx_data_q;
    byte_valid_nxt  = 1'b0;
    bit_discard_nxt = 1'b0;
    stuff_err_nxt   = stuff_err_q;
    byte_err_nxt    = byte_err_q;
    pkt_done_nxt    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start_rx) begin
          state_nxt     = RECV;
          bit_cnt_nxt   = 3'd0;
          ones_cnt_nxt  = 3'd0;
          stuff_err_nxt = 1'b0;
          byte_err_nxt  = 1'b0;
        end
      end

      RECV: begin
        // eop wins over a coincident strobe; that bit is simply dropped
        if (bus.eop) begin
          pkt_done_nxt = 1'b1;
          if (bit_cnt != 3'd0) byte_err_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (bus.shift_enable) begin
          shreg_nxt   = {bus.d_orig, shreg[7:1]};
          bit_cnt_nxt = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            rx_data_nxt    = {bus.d_orig, shreg[7:1]};
            byte_valid_nxt = 1'b1;
          end
          if (bus.d_orig) begin
            ones_cnt_nxt = ones_cnt + 3'd1;
            if (ones_cnt == 3'd5) state_nxt = STUFF;
          end else begin
            ones_cnt_nxt = 3'd0;
          end
        end
      end

      STUFF: begin
        if (bus.eop) begin
          pkt_done_nxt = 1'b1;
          if (bit_cnt != 3'd0) byte_err_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (bus.shift_enable) begin
          if (!bus.d_orig) begin
            bit_discard_nxt = 1'b1;
            ones_cnt_nxt    = 3'd0;
            state_nxt       = RECV;
          end else begin
            stuff_err_nxt = 1'b1;
            state_nxt     = ERROR;
          end
        end
      end

      ERROR: begin
        if (bus.eop) begin
          pkt_done_nxt = 1'b1;
          state_nxt    = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      bit_cnt       <= 3'd0;
      ones_cnt      <= 3'd0;
      shreg         <= 8'h00;
      rx_data_q     <= 8'h00;
      byte_valid_q  <= 1'b0;
      bit_discard_q <= 1'b0;
      stuff_err_q   <= 1'b0;
      byte_err_q    <= 1'b0;
      pkt_done_q    <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      bit_cnt       <= bit_cnt_nxt;
      ones_cnt      <= ones_cnt_nxt;
      shreg         <= shreg_nxt;
      rx_data_q     <= rx_data_nxt;
      byte_valid_q  <= byte_valid_nxt;
      bit_discard_q <= bit_discard_nxt;
      stuff_err_q   <= stuff_err_nxt;
      byte_err_q    <= byte_err_nxt;
      pkt_done_q    <= pkt_done_nxt;
      busy_q        <= busy_nxt;
    end
  end

  assign bus.rx_data     = rx_data_q;
  assign bus.byte_valid  = byte_valid_q;
  assign bus.bit_discard = bit_discard_q;
  assign bus.stuff_err   = stuff_err_q;
  assign bus.byte_err    = byte_err_q;
  assign bus.pkt_done    = pkt_done_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_usb_rx_unstuff_ctrl.sv
// Scoreboard bench for usb_rx_unstuff_ctrl: a packet-level reference model queues expected
// bytes, discards and packet closures; a negedge monitor pops and compares them.
module tb_usb_rx_unstuff_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b1;
  always #5 clk = ~clk;

  usb_rx_unstuff_ctrl_if bus();

  usb_rx_unstuff_ctrl dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  bit mon_en = 1'b0;

  // reference model state: packet open, errored, waiting for a stuffed zero
  bit         m_active, m_err, m_await;
  int         m_ones, m_bits;
  logic [7:0] m_byte, exp_rx;
  logic       m_stuff_err, m_byte_err;

  logic [7:0] byte_q[$];
  int         disc_q[$];
  logic [1:0] pkt_q[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_err = 0; m_await = 0; m_ones = 0; m_bits = 0;
    m_byte = 8'h00; exp_rx = 8'h00; m_stuff_err = 1'b0; m_byte_err = 1'b0;
    byte_q.delete(); disc_q.delete(); pkt_q.delete();
  endtask

  task automatic model_step(input logic st, input logic se, input logic d, input logic e);
    if (!m_active) begin
      if (st) begin
        m_active = 1; m_err = 0; m_await = 0; m_ones = 0; m_bits = 0;
        m_stuff_err = 1'b0; m_byte_err = 1'b0;
      end
      return;
    end
    if (e) begin
      if (!m_err && m_bits != 0) m_byte_err = 1'b1;
      pkt_q.push_back({m_byte_err, m_stuff_err});
      m_active = 0;
      return;
    end
    if (!se || m_err) return;
    if (m_await) begin
      if (!d) begin
        disc_q.push_back(m_bits);
        m_await = 0;
        m_ones = 0;
      end else begin
        m_stuff_err = 1'b1;
        m_err = 1;
      end
      return;
    end
    m_byte[m_bits] = d;
    m_bits++;
    if (m_bits == 8) begin
      byte_q.push_back(m_byte);
      exp_rx = m_byte;
      m_bits = 0;
    end
    m_ones = d ? m_ones + 1 : 0;
    if (m_ones == 6) m_await = 1;
  endtask

  task automatic clear_inputs();
    bus.start_rx = 1'b0; bus.shift_enable = 1'b0; bus.d_orig = 1'b0; bus.eop = 1'b0;
  endtask

  task automatic drive(input logic st, input logic se, input logic d, input logic e);
    bus.start_rx = st; bus.shift_enable = se; bus.d_orig = d; bus.eop = e;
    @(posedge clk);
    model_step(st, se, d, e);
    #1;
    clear_inputs();
  endtask

  task automatic strobe(input logic d);
    drive(1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) strobe(b[i]);
  endtask

  task automatic do_reset();
    n_rst = 1'b1;
    bus.start_rx = 1'($urandom); bus.shift_enable = 1'($urandom);
    bus.d_orig = 1'($urandom); bus.eop = 1'($urandom);
    @(posedge clk);
    if (mon_en) chk("pending_at_reset", 8'(byte_q.size() + disc_q.size() + pkt_q.size()), 8'd0);
    model_reset();
    mon_en = 1'b1;
    #1;
    n_rst = 1'b0;
    clear_inputs();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("byte_valid", 8'(bus.byte_valid), 8'(byte_q.size() != 0));
      if (bus.byte_valid && byte_q.size() != 0) chk("rx_byte", bus.rx_data, byte_q.pop_front());
      else if (byte_q.size() != 0) void'(byte_q.pop_front());
      chk("bit_discard", 8'(bus.bit_discard), 8'(disc_q.size() != 0));
      if (disc_q.size() != 0) void'(disc_q.pop_front());
      chk("pkt_done", 8'(bus.pkt_done), 8'(pkt_q.size() != 0));
      if (bus.pkt_done && pkt_q.size() != 0) chk("pkt_flags", 8'({bus.byte_err, bus.stuff_err}), 8'(pkt_q.pop_front()));
      else if (pkt_q.size() != 0) void'(pkt_q.pop_front());
      chk("rx_data_hold", bus.rx_data, exp_rx);
      chk("busy", 8'(bus.busy), 8'(m_active));
      chk("stuff_err", 8'(bus.stuff_err), 8'(m_stuff_err));
      chk("byte_err", 8'(bus.byte_err), 8'(m_byte_err));
    end
  end

  int p_one;

  initial begin
    clear_inputs();
    model_reset();
    do_reset();
    chk("reset_outputs", 8'({bus.byte_valid, bus.bit_discard, bus.stuff_err, bus.byte_err,
                              bus.pkt_done, bus.busy}), 8'h00);
    chk("reset_rx_data", bus.rx_data, 8'h00);

    // plain byte
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'hA5);
    idle();
    chk("byte_a5", bus.rx_data, 8'hA5);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // six ones, stuffed zero, two more ones
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) strobe(1'b1);
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    idle();
    chk("byte_ff", bus.rx_data, 8'hFF);
    chk("no_stuff_err", 8'(bus.stuff_err), 8'h00);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // seventh one is a stuffing violation
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) strobe(1'b1);
    idle();
    chk("stuff_err_set", 8'(bus.stuff_err), 8'h01);
    for (int i = 0; i < 5; i++) strobe(1'($urandom));
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("err_closed_busy", 8'(bus.busy), 8'h00);
    chk("stuff_err_sticky", 8'(bus.stuff_err), 8'h01);

    // partial byte then clearing start
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) strobe(1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    chk("byte_err_set", 8'(bus.byte_err), 8'h01);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("byte_err_cleared", 8'(bus.byte_err), 8'h00);

    // eop together with the eighth strobe
    for (int i = 0; i < 7; i++) strobe(1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("eop_vs_eighth", 8'(bus.byte_err), 8'h01);
    idle();

    // reset mid-packet, then a clean packet
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1);
    do_reset();
    chk("midreset_outputs", 8'({bus.rx_data, bus.byte_valid, bus.bit_discard, bus.stuff_err,
                                 bus.byte_err, bus.pkt_done, bus.busy} != 0), 8'h00);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    send_byte(8'h3C);
    idle();
    chk("byte_3c", bus.rx_data, 8'h3C);
    drive(1'b0, 1'b0, 1'b0, 1'b1);

    // randomized traffic with varying density of ones
    p_one = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0: p_one = 50;
          1: p_one = 88;
          default: p_one = 97;
        endcase
      end
      if ($urandom_range(0, 199) == 0) do_reset();
      else drive(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 99) < p_one), 1'($urandom_range(0, 49) == 0));
    end
    idle();
    idle();
    chk("queues_drained", 8'(byte_q.size() + disc_q.size() + pkt_q.size()), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/usb_rx_unstuff_ctrl.md
USB_RX_UNSTUFF_CTRL -- requirements
Module: usb_rx_unstuff_ctrl

Interface
REQ-001 SHALL implement the decided clocking: one clock; reset is synchronous and active-high.
REQ-002 SHALL provide the following ports:
- clk  in  1  rising-edge clock.
- n_rst  in  1  synchronous, active-high reset; the codebase name is kept, polarity is high.
- start_rx  in  1  one-cycle pulse; SYNC detected upstream; begins a packet.
- shift_enable  in  1  one-cycle bit strobe; d_orig is valid only when this is high.
- d_orig  in  1  NRZI-decoded line bit.
- eop  in  1  one-cycle pulse; end of packet (SE0) detected.
- rx_data  out  8  last assembled byte.
- byte_valid  out  1  one-cycle pulse; rx_data updated.
- bit_discard  out  1  one-cycle pulse; stuffed bit removed.
- stuff_err  out  1  sticky; illegal seventh 1 seen.
- byte_err  out  1  sticky; EOP arrived with a partial byte.
- pkt_done  out  1  one-cycle pulse; packet closed.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, RECV, STUFF and ERROR, with a 3-bit bit_cnt (0-7), a 3-bit ones_cnt (0-6) and an 8-bit shift register.
REQ-004 IDLE: on start_rx, go to RECV; clear bit_cnt, ones_cnt, stuff_err and byte_err. All other inputs are ignored.
REQ-005 start_rx SHALL be ignored in every state except IDLE.
REQ-006 RECV, on shift_enable:
- shift d_orig into the register MSB with a right shift, so data is assembled LSB-first.
- bit_cnt SHALL increment and wrap from 7 to 0.
REQ-007 When the strobe sets the eighth bit (bit_cnt=7), rx_data SHALL load the complete byte on that same clock edge, and byte_valid SHALL be high for exactly the next cycle.
REQ-008 RECV ones counting:
- d_orig=1 increments ones_cnt.
- d_orig=0 clears ones_cnt.
- When ones_cnt reaches 6, the FSM SHALL go to STUFF.
REQ-009 If the sixth consecutive 1 is also the eighth bit of a byte, byte_valid SHALL still be issued and the FSM SHALL still enter STUFF.
REQ-010 STUFF, on shift_enable:
- d_orig=0: pulse bit_discard for one cycle, clear ones_cnt and return to RECV. bit_cnt and the shift register are unchanged.
- d_orig=1: set stuff_err and go to ERROR.
REQ-011 ERROR SHALL ignore all shift_enable strobes and SHALL NOT produce byte_valid or bit_discard.
REQ-012 eop in RECV or STUFF SHALL do all of the following:
- pulse pkt_done for one cycle.
- set byte_err if bit_cnt≠0.
- go to IDLE.
REQ-013 eop in ERROR SHALL pulse pkt_done and go to IDLE.
REQ-014 If eop and shift_enable are high in the same cycle, eop SHALL take priority and the bit SHALL be discarded without effect.
REQ-015 stuff_err and byte_err SHALL hold their value until the next accepted start_rx or reset.
REQ-016 rx_data SHALL hold its last value until the next completed byte.
REQ-017 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-018 When n_rst=1 at a rising edge, the block SHALL, on that edge:
- enter IDLE.
- clear all counters and the shift register.
- set rx_data=0x00.
- drive byte_valid, bit_discard, stuff_err, byte_err, pkt_done and busy to 0.
REQ-019 Reset SHALL override all other inputs in the same cycle, including mid-packet and mid-STUFF, and no pulse output SHALL be emitted after it.

Verification
REQ-020 Byte assembly: start_rx, then strobes with bits 1,0,1,0,0,1,0,1 -> byte_valid high for one cycle immediately after the eighth strobe; rx_data=0xA5; no bit_discard.
REQ-021 Stuffed byte: strobes with bits 1,1,1,1,1,1,0,1,1 -> exactly one bit_discard pulse after the seventh strobe; byte_valid after the ninth strobe; rx_data=0xFF; stuff_err=0.
REQ-022 Stuff error: seven consecutive 1 strobes -> stuff_err=1, FSM in ERROR, no byte_valid; further strobes ignored; then eop -> pkt_done pulse, busy=0, stuff_err still 1.
REQ-023 Partial byte: three strobes, then eop -> pkt_done pulse, byte_err=1, busy=0; the next start_rx clears byte_err.
REQ-024 Simultaneous events: eop together with the eighth strobe -> no byte_valid, byte_err=1, pkt_done pulse.
REQ-025 Mid-packet reset: n_rst=1 after five bits -> all outputs 0 on the next cycle; the following packet 0x3C assembles correctly.
